// File: rtl/uart_rx2_pkg.sv
// uart_rx2_pkg: shared definitions for the 8N1 UART receiver.
//   - Default clock and baud rates, and the clocks-per-bit / half-bit derivation.
//   - FSM state encodings. These are common with the uart_tx2 transmitter, so keep them in sync.
package uart_rx2_pkg;

  localparam int unsigned DefClkHz    = 12_000_000;
  localparam int unsigned DefUartBaud = 9600;

  // FSM state encodings
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t StIdle    = 3'd0;
  localparam rx_state_t StStart   = 3'd1;
  localparam rx_state_t StData    = 3'd2;
  localparam rx_state_t StStop    = 3'd3;
  localparam rx_state_t StCleanup = 3'd4;

  // Clocks per bit (S) for a given clock frequency and line rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Half-bit point H = (S-1)/2, rounded down. This is where the start bit is validated.
  function automatic int unsigned half_bit(input int unsigned s);
    return (s - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx2_sync2.sv
// uart_rx2_sync2: two-flop synchroniser for an asynchronous single-bit input.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset; both flops load RESET_VAL
//   d_i     : asynchronous input
//   q_o     : d_i delayed by two clk_i flops
module uart_rx2_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx2.sv
// uart_rx2: 8N1 UART receiver. The line is LSB first and idles high.
// The start bit is validated at mid-bit. Data bits and the stop bit are sampled at bit centres.
//   clk_i       : system clock, all logic on the rising edge
//   rst_ni      : asynchronous active-low reset; aborts any frame in progress
//   rx_data_i   : serial line, asynchronous to clk_i
//   rx_byte_o   : last correctly framed byte; holds until the next good byte
//   rx_dv_o     : one-cycle strobe; rx_byte_o is valid in the same cycle
//   frame_err_o : one-cycle strobe when the stop bit samples low
//   busy_o      : high whenever the receiver is not idle
module uart_rx2
  import uart_rx2_pkg::*;
#(
  parameter int unsigned UART_BAUD    = DefUartBaud,
  parameter int unsigned CLK_HZ       = DefClkHz,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, UART_BAUD)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_dv_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned S    = CLKS_PER_BIT;
  localparam int unsigned H    = half_bit(S);
  localparam int unsigned CntW = $clog2(S);

  // Compare constants are sized to the counter, so S-1 never wraps.
  localparam logic [CntW-1:0] CntHalf = CntW'(H);
  localparam logic [CntW-1:0] CntLast = CntW'(S - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx2: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;

  uart_rx2_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_data_i),
    .q_o    (rx_s)
  );

  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          // If the line is high again at mid-start-bit, it was a glitch: drop back silently.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            // Returning to idle at mid-stop-bit leaves half a bit to catch a back-to-back start.
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StCleanup;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StCleanup: begin
        // A held-low break must not retrigger a start, so wait for the line to go high.
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte_o   = byte_q;
  assign rx_dv_o     = dv_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx2.sv
// Bench for uart_rx2. A behavioural 8N1 line driver produces the stimulus. The expected
// strobes (kind, byte and cycle) are queued from each frame as it is sent. One compare
// process checks the strobes and the held byte against this queue on every cycle.
module tb_uart_rx2;

  localparam int S     = 16;
  localparam int SB    = 1250;
  localparam int LatA  = 154;    // 3 + 7 + 9*16
  localparam int LatB  = 11877;  // 3 + 624 + 9*1250
  localparam int HalfP = 50;
  localparam int BitP  = 1600;   // S * clock period
  localparam int BitHi = 1632;   // +2%
  localparam int BitLo = 1568;   // -2%

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic [7:0] byte_a, byte_b;
  logic dv_a, fe_a, busy_a, dv_b, fe_b, busy_b;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] model_byte = 8'h00;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         at;      // expected cycle, or -1 when the tx period is off nominal
  } ev_t;
  ev_t exp_q[$];
  ev_t ev;

  int e0, r, hit_cyc;
  bit found, fe_seen;
  logic [7:0] got;

  uart_rx2 #(.CLKS_PER_BIT(S)) dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_a),
    .rx_byte_o   (byte_a),
    .rx_dv_o     (dv_a),
    .frame_err_o (fe_a),
    .busy_o      (busy_a)
  );

  uart_rx2 dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_b),
    .rx_byte_o   (byte_b),
    .rx_dv_o     (dv_b),
    .frame_err_o (fe_b),
    .busy_o      (busy_b)
  );

  always #HalfP clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(HalfP * 2 * 60000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive one frame on rx_a. Call at a negedge; the task returns at a negedge.
  task automatic send_a(input logic [7:0] b, input bit stop, input int extra_low);
    exp_q.push_back('{is_err: !stop, b: b, at: cyc + 1 + LatA});
    rx_a = 1'b0;
    repeat (S) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = b[i];
      repeat (S) @(negedge clk);
    end
    rx_a = stop;
    repeat (S) @(negedge clk);
    repeat (extra_low) @(negedge clk);
    rx_a = 1'b1;
  endtask

  // Frame on rx_a with an arbitrary bit period in time units.
  task automatic send_timed(input logic [7:0] b, input int per);
    exp_q.push_back('{is_err: 1'b0, b: b, at: -1});
    rx_a = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx_a = b[i];
      #(per);
    end
    rx_a = 1'b1;
    #(per);
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_b = 1'b0;
    repeat (SB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_b = b[i];
      repeat (SB) @(negedge clk);
    end
    rx_b = 1'b1;
    repeat (SB) @(negedge clk);
  endtask

  // Strobe and held-byte scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      model_byte = 8'h00;
    end else begin
      if (dv_a || fe_a) begin
        chk("dv_fe_exclusive", {31'd0, dv_a & fe_a}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, dv_a, fe_a}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", {30'd0, dv_a, fe_a}, ev.is_err ? 32'd1 : 32'd2);
          if (!ev.is_err) begin
            chk("strobe_byte", {24'd0, byte_a}, {24'd0, ev.b});
            model_byte = ev.b;
          end
          if (ev.at >= 0) chk("strobe_cycle", cyc, ev.at);
        end
      end
      chk("rx_byte_hold", {24'd0, byte_a}, {24'd0, model_byte});
    end
  end

  initial begin
    // Reset takes effect immediately, without a clock edge
    #20 rst_n = 1'b0;
    #10;
    chk("reset_byte", {24'd0, byte_a}, 32'd0);
    chk("reset_dv", {31'd0, dv_a}, 32'd0);
    chk("reset_fe", {31'd0, fe_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    repeat (3) @(negedge clk);
    #20 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 with literal timing
    e0 = cyc + 1;
    fork
      send_a(8'hA5, 1'b1, 0);
      begin
        wait_cyc(e0 + 1);   chk("a5_busy_e1", {31'd0, busy_a}, 32'd0);
        wait_cyc(e0 + 2);   chk("a5_busy_e2", {31'd0, busy_a}, 32'd1);
        wait_cyc(e0 + 153); chk("a5_busy_e153", {31'd0, busy_a}, 32'd1);
        chk("a5_dv_e153", {31'd0, dv_a}, 32'd0);
        wait_cyc(e0 + 154); chk("a5_dv_e154", {31'd0, dv_a}, 32'd1);
        chk("a5_byte_e154", {24'd0, byte_a}, 32'hA5);
        chk("a5_busy_e154", {31'd0, busy_a}, 32'd0);
      end
    join
    repeat (8) @(negedge clk);

    // Glitch: the line is low for 3 clocks
    e0 = cyc + 1;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    wait_cyc(e0 + 5);  chk("glitch_busy_mid", {31'd0, busy_a}, 32'd1);
    wait_cyc(e0 + 11); chk("glitch_busy_end", {31'd0, busy_a}, 32'd0);
    repeat (20) @(negedge clk);
    chk("glitch_byte", {24'd0, byte_a}, 32'hA5);

    // Framing error: stop bit low, then 40 more clocks low
    e0 = cyc + 1;
    fork
      send_a(8'h3C, 1'b0, 40);
      begin
        wait_cyc(e0 + 154); chk("ferr_e154", {31'd0, fe_a}, 32'd1);
      end
    join
    r = cyc;
    wait_cyc(r + 2); chk("cleanup_busy_hi", {31'd0, busy_a}, 32'd1);
    wait_cyc(r + 3); chk("cleanup_busy_lo", {31'd0, busy_a}, 32'd0);
    chk("ferr_byte_kept", {24'd0, byte_a}, 32'hA5);
    repeat (10) @(negedge clk);

    // Back-to-back frames: nominal, +2%, -2%
    send_a(8'h00, 1'b1, 0);
    send_a(8'hFF, 1'b1, 0);
    repeat (10) @(negedge clk);
    send_timed(8'h00, BitHi);
    send_timed(8'hFF, BitHi);
    @(negedge clk);
    repeat (10) @(negedge clk);
    send_timed(8'h00, BitLo);
    send_timed(8'hFF, BitLo);
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("b2b_byte", {24'd0, byte_a}, 32'hFF);

    // Reset during data bit 3 aborts the frame
    e0 = cyc + 1;
    rx_a = 1'b0;
    repeat (S) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_a = (i % 2 == 0);
      if (i < 3) repeat (S) @(negedge clk);
    end
    wait_cyc(e0 + 66);
    chk("abort_busy_pre", {31'd0, busy_a}, 32'd1);
    #20 rst_n = 1'b0;
    #10;
    chk("abort_byte", {24'd0, byte_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_dv", {31'd0, dv_a}, 32'd0);
    chk("abort_fe", {31'd0, fe_a}, 32'd0);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    #20 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_a(8'h55, 1'b1, 0);
    repeat (10) @(negedge clk);
    chk("after_abort_byte", {24'd0, byte_a}, 32'h55);

    // Loopback-style frame at S=1250
    e0 = cyc + 1;
    found = 1'b0;
    fe_seen = 1'b0;
    hit_cyc = -1;
    got = 8'h00;
    fork
      send_b(8'h7E);
      begin
        while (!found && cyc < e0 + LatB + 20) begin
          @(negedge clk);
          if (fe_b) fe_seen = 1'b1;
          if (dv_b) begin
            found = 1'b1;
            hit_cyc = cyc;
            got = byte_b;
          end
        end
      end
    join
    chk("lb_found", {31'd0, found}, 32'd1);
    chk("lb_cycle", hit_cyc, e0 + LatB);
    chk("lb_byte", {24'd0, got}, 32'h7E);
    chk("lb_no_ferr", {31'd0, fe_seen}, 32'd0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
